// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared types and the bitwise operation function for logic_unit_pipe.
//   op_e      : 3-bit operation select (NOT, BUF, AND, OR, XOR, NAND, NOR, XNOR)
//   occ_e     : skid-buffer occupancy (EMPTY, ONE, FULL)
//   apply_op  : bitwise result over LU_MAX_W bits; callers zero-extend their
//               operands and keep the low WIDTH bits of the result.
package logic_unit_pkg;

    // Widest operand apply_op handles; instantiations must keep WIDTH <= LU_MAX_W.
    localparam int LU_MAX_W = 256;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_BUF  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Upper bits beyond the caller's WIDTH are meaningless (NOT of zero
    // padding yields ones) and are simply discarded by the caller.
    function automatic logic [LU_MAX_W-1:0] apply_op(
        input op_e                 op,
        input logic [LU_MAX_W-1:0] a,
        input logic [LU_MAX_W-1:0] b
    );
        logic [LU_MAX_W-1:0] y;
        case (op)
            OP_NOT:  y = ~a;
            OP_BUF:  y = a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2
// Generic 2-entry valid/ready skid buffer: a head (output) register plus one
// skid register, tracked by an occupancy FSM. in_ready depends only on the
// registered occupancy, so there is no combinational out_ready -> in_ready path.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data = head register
module skid_buf2
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    occ_e             state_reg;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             accept;
    logic             pop;

    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = head_reg;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        head_reg  <= in_data;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            // Head is stalled: park the new beat behind it.
                            skid_reg  <= in_data;
                            state_reg <= FULL;
                        end
                        2'b01: state_reg <= EMPTY;
                        2'b11: head_reg  <= in_data;
                        default: ;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_reg  <= skid_reg;
                        state_reg <= ONE;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Registered bitwise logic unit on a valid/ready stream with a saturating
// count of delivered results.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_op selects the operation,
//                         in_a/in_b are the WIDTH-bit operands
//   out_valid/out_ready : result handshake; out_y is the result
//   cnt_clr             : synchronous clear of done_cnt (wins over a pop)
//   done_cnt            : saturating count of popped results
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_cnt
);

    logic [LU_MAX_W-1:0] result_full;
    logic [WIDTH-1:0]    result;
    logic [CNT_W-1:0]    cnt_reg;
    logic                pop;

    assign result_full = apply_op(op_e'(in_op), LU_MAX_W'(in_a), LU_MAX_W'(in_b));
    assign result      = result_full[WIDTH-1:0];

    // Fold the discarded upper result bits into a sink so they are visibly consumed.
    generate
        if (WIDTH < LU_MAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^result_full[LU_MAX_W-1:WIDTH];
        end
    endgenerate

    skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_y)
    );

    assign pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (pop && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign done_cnt = cnt_reg;

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit: the generalised successor to the single-bit inverter. It applies one of eight bitwise operations to two WIDTH-bit operands and delivers results over a valid/ready stream. A 2-entry skid buffer sustains full throughput under backpressure. The block sits between any stream producer and consumer in the datapath and keeps a saturating count of delivered results.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- CNT_W, 16, width of the delivered-result counter (≥1)

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- in_op  in  3  operation select (encoding below)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored for NOT and BUF)
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the beat
- out_y  out  WIDTH  result
- cnt_clr  in  1  synchronous clear of done_cnt
- done_cnt  out  CNT_W  saturating count of delivered results

## Operation
- Op encoding: 0 NOT a; 1 BUF a; 2 AND; 3 OR; 4 XOR; 5 NAND; 6 NOR; 7 XNOR. All ops are bitwise over WIDTH bits.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Result is computed combinationally from in_op/in_a/in_b and is captured only on accept. Operands need not be held after accept.
- Storage: output register (head) plus one skid register. State is the occupancy: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: accept -> ONE, result into head.
  - ONE: accept & !pop -> FULL, result into skid. pop & !accept -> EMPTY. accept & pop -> ONE, head loads new result.
  - FULL: accept is impossible. pop -> ONE, skid moves to head.
- in_ready = (state != FULL). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_y = head register.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- done_cnt increments by 1 on each pop and saturates at all-ones.
- cnt_clr forces done_cnt to 0 next cycle. If cnt_clr and pop occur in the same cycle, clear wins and the result is 0.
- Reset (rst_n low at a clock edge) has these effects:
  - state -> EMPTY, out_valid 0, out_y 0, done_cnt 0, skid register 0, in_ready 1.
  - Any beat in flight is discarded, and in_valid is ignored in that cycle.
  - Reset mid-operation loses buffered beats without producing output.

## Timing
- Latency: a beat accepted at edge N is visible on out_y/out_valid after edge N (one cycle).
- Throughput: one beat per cycle whenever out_ready is held high.
- Backpressure: with out_ready low, the block absorbs 2 beats, then in_ready drops in the cycle after the second accept.
- Recovery: after out_ready rises in FULL, in_ready is 1 in the cycle after the first pop.
- out_y and out_valid must stay stable while out_valid=1 and out_ready=0.
- done_cnt reflects a pop one cycle after it occurs.

## Structure
- Shared package logic_unit_pkg:
  - op enum op_e (OP_NOT..OP_XNOR, 3-bit);
  - occupancy enum occ_e (EMPTY, ONE, FULL);
  - function apply_op(op, a, b) returning the WIDTH-bit result.
- One natural sub-module, skid_buf2: a generic WIDTH-bit 2-entry valid/ready skid buffer holding the occupancy FSM.
- Top level = apply_op + skid_buf2 + saturating counter.

## Test plan
All cases use WIDTH=8, CNT_W=16 unless noted.
- Op sweep: op 0..7 with a=0xA5, b=0x0F, out_ready=1 -> y = 0x5A, 0xA5, 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, one cycle after each accept. done_cnt=8.
- Backpressure and FIFO order:
  - out_ready=0, drive a=0x01, 0x02, 0x03 with op BUF -> in_ready falls after 2 accepts and 0x03 is held off.
  - Raise out_ready -> outputs in order 0x01, 0x02, 0x03, with no gaps once flowing.
- Simultaneous accept/pop in ONE at full rate with a random out_ready pattern -> scoreboard matches every beat, and out_y is stable whenever stalled.
- Counter:
  - CNT_W=2: 5 pops -> done_cnt 1, 2, 3, 3, 3.
  - cnt_clr asserted together with a pop -> done_cnt=0.
- Reset mid-operation: in FULL state, assert rst_n=0 for 1 cycle.
  - Required: out_valid=0, out_y=0x00, done_cnt=0, in_ready=1.
  - Next beat (NOT 0x00) -> y=0xFF.
